// File: rtl/sm_argmax_if.sv
// Score stream between the adder tree and the argmax stage.
// Source drives in_valid/in_data; the argmax stage answers with in_ready.
interface sm_argmax_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sm_argmax.sv
// Running argmax over one frame of NUM_CLASSES sign-magnitude scores.
//
// state   | meaning
// IDLE    | waiting for start, stream not accepted
// COLLECT | accepting scores, tracking running maximum
// DONE    | one-cycle result pulse
module sm_argmax #(
  parameter int WIDTH       = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sm_argmax_if.slave           s_in,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_WIDTH-1:0] max_index,
  output logic [WIDTH-1:0]     max_value
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  logic [1:0]           state;
  logic [IDX_WIDTH-1:0] count;
  logic                 take;

  // Strict sign-magnitude greater-than; +0 and -0 are equal.
  function automatic logic sm_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic             sa, sb;
    logic [WIDTH-2:0] ma, mb;
    sa = a[WIDTH-1];
    sb = b[WIDTH-1];
    ma = a[WIDTH-2:0];
    mb = b[WIDTH-2:0];
    if ((ma == '0) && (mb == '0))
      sm_gt = 1'b0;
    else if (sa != sb)
      sm_gt = ~sa;
    else if (!sa)
      sm_gt = (ma > mb);
    else
      sm_gt = (ma < mb);
  endfunction

  assign s_in.in_ready = (state == ST_COLLECT);
  assign busy          = (state == ST_COLLECT);
  assign done          = (state == ST_DONE);

  // A score arriving together with an abort start is dropped.
  assign take = (state == ST_COLLECT) && s_in.in_valid && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_COLLECT;
            count <= '0;
          end
        end
        ST_COLLECT: begin
          if (start) begin
            count <= '0;
          end else if (take) begin
            if ((count == '0) || sm_gt(s_in.in_data, max_value)) begin
              max_value <= s_in.in_data;
              max_index <= count;
            end
            count <= count + 1'b1;
            if (count == LAST_IDX)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          count <= '0;
          state <= start ? ST_COLLECT : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_argmax.sv
// Directed bench for sm_argmax (WIDTH=8): integer-valued frame model
// checked every cycle, plus literal per-frame expectations.
module tb_sm_argmax;
  localparam int W = 8;
  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] max_index;
  logic [7:0] max_value;

  sm_argmax_if #(.WIDTH(W)) bus ();

  sm_argmax #(.WIDTH(W), .NUM_CLASSES(N), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .s_in(bus),
    .busy(busy), .done(done), .max_index(max_index), .max_value(max_value)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [7:0] frame [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame contents as signed integers, result = first index of the maximum.
  int         m_phase = 0;   // 0 waiting, 1 collecting, 2 result cycle
  int         q_int[$];
  logic [7:0] q_raw[$];
  int         m_idx = 0;
  logic [7:0] m_val = '0;

  function automatic int sm2int(input logic [7:0] b);
    return b[7] ? -int'(b[6:0]) : int'(b[6:0]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      q_int.delete();
      q_raw.delete();
      m_idx = 0;
      m_val = '0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; q_int.delete(); q_raw.delete(); end
        1: begin
          if (start) begin
            q_int.delete();
            q_raw.delete();
          end else if (bus.in_valid) begin
            int best;
            q_int.push_back(sm2int(bus.in_data));
            q_raw.push_back(bus.in_data);
            best = 0;
            for (int i = 1; i < q_int.size(); i++)
              if (q_int[i] > q_int[best]) best = i;
            m_idx = best;
            m_val = q_raw[best];
            if (q_int.size() == N) m_phase = 2;
          end
        end
        default: begin
          m_phase = start ? 1 : 0;
          q_int.delete();
          q_raw.delete();
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", bus.in_ready, m_phase == 1);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("max_index", max_index, m_idx);
      chk("max_value", max_value, m_val);
      if (done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends frame[0..cnt-1]; with bp set, random idle cycles are inserted.
  task automatic send_frame(input int cnt, input bit bp);
    for (int i = 0; i < cnt; i++) begin
      if (bp) begin
        for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          tick();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [3:0] idx, input logic [7:0] val);
    chk({name, "_done_latency"}, done, 1);
    chk({name, "_index"}, max_index, idx);
    chk({name, "_value"}, max_value, val);
    tick();
    chk({name, "_done_single"}, done, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_index", max_index, 0);
    chk("reset_value", max_value, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Mixed signs, tie at index 3 must not displace index 2.
    frame = '{8'h03, 8'h87, 8'h09, 8'h09, 8'h81, 8'h00, 8'h02, 8'h89, 8'h08, 8'h01};
    pulse_start();
    send_frame(N, 1'b0);
    check_result("mixed", 4'd2, 8'h09);

    // All negative.
    frame = '{8'h85, 8'h82, 8'h88, 8'h82, 8'h89, 8'h83, 8'h84, 8'h86, 8'h87, 8'h8a};
    pulse_start();
    send_frame(N, 1'b0);
    check_result("negative", 4'd1, 8'h82);

    // -0 first, +0 later compares equal and is not taken; start during DONE.
    frame = '{8'h80, 8'h81, 8'h85, 8'h83, 8'h00, 8'h82, 8'h84, 8'h86, 8'h87, 8'h88};
    pulse_start();
    send_frame(N, 1'b0);
    chk("zero_done_latency", done, 1);
    chk("zero_index", max_index, 0);
    chk("zero_value", max_value, 8'h80);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_from_done_busy", busy, 1);

    // Backpressure with random gaps.
    frame = '{8'h01, 8'h85, 8'h03, 8'h0a, 8'h80, 8'h07, 8'h02, 8'h14, 8'h13, 8'h81};
    send_frame(N, 1'b1);
    check_result("backpressure", 4'd7, 8'h14);

    // Abort after 4 transfers; the score sent with the second start is dropped.
    n_done = 0;
    frame = '{8'h02, 8'h32, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(4, 1'b0);
    chk("abort_partial_index", max_index, 1);
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h64;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    frame = '{8'h01, 8'h82, 8'h03, 8'h00, 8'h04, 8'h85, 8'h05, 8'h02, 8'h85, 8'h03};
    send_frame(N, 1'b0);
    check_result("abort", 4'd6, 8'h05);
    chk("abort_done_count", n_done, 1);

    // Asynchronous reset mid-frame.
    n_done = 0;
    frame = '{8'h10, 8'h7f, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_index", max_index, 0);
    chk("async_rst_value", max_value, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    tick();
    chk("async_rst_done_count", n_done, 0);
    frame = '{8'h03, 8'h87, 8'h09, 8'h09, 8'h81, 8'h00, 8'h02, 8'h89, 8'h08, 8'h01};
    pulse_start();
    send_frame(N, 1'b0);
    check_result("after_rst", 4'd2, 8'h09);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sm_argmax.md
Name: sm_argmax

Overview:
- Streaming consumer of sign-magnitude class scores produced by the sign-magnitude adder tree of the classifier datapath.
- Accepts exactly NUM_CLASSES scores per frame over a valid/ready handshake and tracks the running maximum under sign-magnitude ordering.
- Reports the winning class index and its score, which is the final digit decision of the detector.

Parameters:
- WIDTH, 32, score width; MSB is the sign (1 = negative), bits WIDTH-2:0 are the magnitude.
- NUM_CLASSES, 10, number of scores per frame.
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a new frame.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  sign-magnitude score for the current class index.
- in_ready  out  1  block accepts a score this cycle.
- busy  out  1  frame in progress.
- done  out  1  single-cycle pulse; result valid.
- max_index  out  IDX_WIDTH  index of the winning class.
- max_value  out  WIDTH  score of the winning class, in sign-magnitude form.

Behaviour:
- Reset (asynchronous): state = IDLE; in_ready, busy and done = 0; max_index, max_value and the sample counter = 0.
- FSM states are IDLE, COLLECT and DONE.
- IDLE:
  - start=1 -> COLLECT; counter cleared.
  - Other inputs are ignored; in_ready = 0.
- COLLECT:
  - in_ready = 1 and busy = 1.
  - A transfer occurs when in_valid && in_ready.
  - On each transfer the score is tagged with index = counter, and the counter increments.
  - The first transfer of a frame loads max_value and max_index unconditionally.
  - A later transfer replaces max_value and max_index only if the new score is strictly greater than the held score.
- DONE:
  - done = 1 for exactly one cycle, then the FSM returns to IDLE.
  - Entered on the clock edge that accepts transfer number NUM_CLASSES, so latency is 1 cycle from the last accepted score to the done pulse.
- max_index and max_value:
  - Update only on transfers.
  - Hold their values from done until the first transfer of the next frame.
- Comparison, with s = sign bit and m = magnitude:
  - Two +0 / -0 values (m = 0 for both) compare equal.
  - s=0 vs s=1 (not both zero): the positive score is greater.
  - Both positive: the larger m is greater.
  - Both negative: the smaller m is greater.
  - The comparison is purely combinational on the held and incoming scores; no subtraction and no widening.
- Ties: the earlier index is kept, so the lowest index wins among equal scores.
- Handshake: in_valid with in_ready = 0 is not a transfer; data is not captured, and the source must hold it.
- Boundary conditions:
  - start during COLLECT aborts the frame. On the next edge the counter is cleared and the FSM stays in COLLECT. The start-cycle score, if transferred, is discarded. No done pulse is issued for the aborted frame.
  - start during DONE is honoured: done still pulses, and the FSM goes to COLLECT instead of IDLE.
  - in_valid held low in COLLECT: the FSM waits indefinitely with no timeout.
  - The counter never exceeds NUM_CLASSES-1 at a transfer, so there is no wrap within a frame.
  - rst asserted mid-frame: all state is cleared immediately and no done pulse is issued.

Test Plan:
- WIDTH=8, scores +3, -7, +9, +9, -1, +0, +2, -9, +8, +1 (0x03, 0x87, 0x09, 0x09, 0x81, 0x00, 0x02, 0x89, 0x08, 0x01), one per cycle -> done 1 cycle after the 10th transfer; max_index=2, max_value=0x09 (tie with index 3 is not taken).
- All negative: -5, -2, -8, -2, -9, -3, -4, -6, -7, -10 -> max_index=1, max_value=0x82.
- Zero handling: 0x80 (-0) first, 0x00 at index 4, all others negative -> max_index=0, max_value=0x80 (equal, not replaced).
- Backpressure: in_valid toggled randomly 50% across a frame with max +20 at index 7 -> exactly 10 transfers counted; max_index=7; done follows the 10th transfer by 1 cycle.
- Abort: start, 4 transfers including +50 at index 1, second start, then a full 10-score frame with max +5 at index 6 -> single done pulse; max_index=6, max_value=0x05.
- rst pulsed asynchronously mid-frame -> outputs go to 0 without a clock edge; no done pulse; next start and full frame behave normally.
